// File: rtl/lockin_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : lockin_pkg                                             |
// | Description : Shared widths and helpers for the lock-in datapath.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package lockin_pkg;

   localparam int LOCKIN_PROD_W    = 32;
   localparam int LOCKIN_OUT_W     = 16;
   localparam int LOCKIN_MAX_LOG2N = 16;

   // Clamp a signed value to the range of a signed integer of the given
   // width.  The result stays sign-extended to 64 bits so the caller can
   // detect saturation by comparing it with the input.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_shift_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : round_shift_sat                                        |
// | Description : Combinational round-half-up, arithmetic right shift    |
// |               and signed saturation of an accumulator value.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module round_shift_sat
   import lockin_pkg::*;
#(
   parameter int ACC_W = 49,   // must not exceed 64
   parameter int OUT_W = 16,
   parameter int SH_W  = 5
) (
   input  logic signed [ACC_W-1:0] value,
   input  logic        [SH_W-1:0]  shamt,
   output logic signed [OUT_W-1:0] result,
   output logic                    sat
);

   localparam logic signed [ACC_W-1:0] c_ONE = ACC_W'(1);

   logic signed [ACC_W-1:0] w_bias;
   logic signed [ACC_W-1:0] w_rnd;
   logic signed [ACC_W-1:0] w_shift;
   logic signed [63:0]      w_ext;
   logic signed [63:0]      w_clamped;

   // Half an output LSB is added before shifting so the truncating shift
   // rounds to nearest with ties toward +inf; the accumulator carries one
   // spare bit so this addition can never wrap.
   always_comb begin
      w_bias    = (shamt == '0) ? '0 : (c_ONE <<< (shamt - SH_W'(1)));
      w_rnd     = value + w_bias;
      w_shift   = w_rnd >>> shamt;
      w_ext     = 64'(w_shift);
      w_clamped = sat_signed(w_ext, OUT_W);
      result    = w_clamped[OUT_W-1:0];
      sat       = (w_clamped != w_ext);
   end

endmodule
`default_nettype wire

// File: rtl/lockin_decim_avg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lockin_decim_avg                                       |
// | Description : Accumulate-and-dump decimator for the lock-in mixer    |
// |               product. Averages 2^N samples, then rounds, shifts     |
// |               and saturates to the output width.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module lockin_decim_avg
   import lockin_pkg::*;
#(
   parameter int IN_W      = LOCKIN_PROD_W,
   parameter int OUT_W     = LOCKIN_OUT_W,
   parameter int MAX_LOG2N = LOCKIN_MAX_LOG2N,
   parameter int N_W       = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic        [N_W-1:0]   log2_n,
   input  logic                    clear,
   input  logic                    sat_clr,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    sat_flag
);

   localparam int                  c_ACC_W   = IN_W + MAX_LOG2N + 1;
   localparam logic [N_W-1:0]      c_MAX_N   = N_W'(MAX_LOG2N);
   localparam logic [MAX_LOG2N-1:0] c_CNT_ONE = MAX_LOG2N'(1);

   logic signed [c_ACC_W-1:0] r_acc;
   logic        [MAX_LOG2N-1:0] r_cnt;
   logic        [N_W-1:0]     r_n_lat;
   logic signed [c_ACC_W-1:0] r_dump;
   logic                      r_dump_valid;
   logic        [N_W-1:0]     r_n_lat_d;

   logic        [N_W-1:0]     w_n_req;
   logic        [N_W-1:0]     w_n_eff;
   logic        [MAX_LOG2N-1:0] w_last;
   logic                      w_final;
   logic signed [c_ACC_W-1:0] w_sum;
   logic signed [OUT_W-1:0]   w_res;
   logic                      w_sat;

   // The first sample of a block uses the freshly requested exponent, so a
   // block of length 1 is recognised as final on that very sample.
   always_comb begin
      w_n_req = (log2_n > c_MAX_N) ? c_MAX_N : log2_n;
      w_n_eff = (r_cnt == '0) ? w_n_req : r_n_lat;
      w_last  = ~({MAX_LOG2N{1'b1}} << w_n_eff);
      w_final = (r_cnt == w_last);
      w_sum   = r_acc + {{(c_ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
   end

   // Stage 1: accumulate accepted samples and dump the block total.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_n_lat      <= '0;
         r_dump       <= '0;
         r_dump_valid <= 1'b0;
         r_n_lat_d    <= '0;
      end else begin
         r_dump_valid <= 1'b0;
         if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (in_valid) begin
            if (r_cnt == '0)
               r_n_lat <= w_n_req;
            if (w_final) begin
               r_dump       <= w_sum;
               r_dump_valid <= 1'b1;
               r_n_lat_d    <= w_n_eff;
               r_acc        <= '0;
               r_cnt        <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + c_CNT_ONE;
            end
         end
      end
   end

   round_shift_sat #(
      .ACC_W (c_ACC_W),
      .OUT_W (OUT_W),
      .SH_W  (N_W)
   ) u_rss (
      .value  (r_dump),
      .shamt  (r_n_lat_d),
      .result (w_res),
      .sat    (w_sat)
   );

   // Stage 2: publish the scaled block mean; a clear on this edge discards
   // the pending dump so no strobe escapes from a flushed block.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (r_dump_valid && !clear) begin
            out_valid <= 1'b1;
            out_data  <= w_res;
         end
         if (r_dump_valid && !clear && w_sat)
            sat_flag <= 1'b1;
         else if (sat_clr)
            sat_flag <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lockin_decim_avg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lockin_decim_avg                                    |
// | Description : Self-checking bench for lockin_decim_avg with a        |
// |               block-level reference model and random stimulus.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_lockin_decim_avg;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [31:0] in_data = '0;
   logic        [4:0]  log2_n = '0;
   logic               clear = 1'b0;
   logic               sat_clr = 1'b0;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               sat_flag;

   lockin_decim_avg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .log2_n    (log2_n),
      .clear     (clear),
      .sat_clr   (sat_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sat_flag  (sat_flag)
   );

   always #5 clk = ~clk;

   int n_chk   = 0;
   int n_fail  = 0;
   int strobes = 0;
   int cur_ln  = 0;

   // Reference model: the samples of the current block, its exponent, a
   // pending block result, and the expected visible outputs.
   longint blk[$];
   int     n_blk    = 0;
   bit     pend_v   = 0;
   longint pend_val = 0;
   bit     pend_sat = 0;
   bit     e_ov     = 0;
   longint e_od     = 0;
   bit     e_sat    = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Mean of a block: round half up, floor-divide by 2^n, clamp to 16 bits.
   task automatic block_result(input int n, output longint val, output bit sat);
      longint sum = 0;
      longint q;
      foreach (blk[i]) sum += blk[i];
      if (n > 0) sum += (64'sd1 <<< (n - 1));
      q   = sum >>> n;
      sat = 1'b0;
      if (q > 32767) begin q = 32767; sat = 1'b1; end
      if (q < -32768) begin q = -32768; sat = 1'b1; end
      val = q;
   endtask

   task automatic model_edge(input bit v, input longint d, input bit c, input bit sc,
                             input bit r, input int ln);
      if (r) begin
         blk.delete();
         pend_v = 0; e_ov = 0; e_od = 0; e_sat = 0;
         return;
      end
      e_ov = pend_v && !c;
      if (e_ov) e_od = pend_val;
      if (pend_v && !c && pend_sat) e_sat = 1;
      else if (sc) e_sat = 0;
      pend_v = 0;
      if (c) begin
         blk.delete();
      end else if (v) begin
         if (blk.size() == 0) n_blk = (ln > 16) ? 16 : ln;
         blk.push_back(d);
         if (blk.size() == (1 << n_blk)) begin
            block_result(n_blk, pend_val, pend_sat);
            pend_v = 1;
            blk.delete();
         end
      end
   endtask

   // One clock: drive inputs, advance model at the edge, check after it.
   task automatic step(input bit v, input longint d, input bit c, input bit sc,
                       input bit r, input int ln);
      in_valid = v;
      in_data  = d[31:0];
      clear    = c;
      sat_clr  = sc;
      rst      = r;
      log2_n   = ln[4:0];
      @(posedge clk);
      model_edge(v, d, c, sc, r, ln);
      #1;
      if (out_valid === 1'b1) strobes++;
      chk("out_valid", longint'(out_valid), longint'(e_ov));
      chk("out_data", longint'(out_data), e_od);
      chk("sat_flag", longint'(sat_flag), longint'(e_sat));
   endtask

   task automatic smp(input longint d);
      step(1, d, 0, 0, 0, cur_ln);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, cur_ln);
   endtask

   initial begin
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_out_data", longint'(out_data), 0);
      chk("reset_sat_flag", longint'(sat_flag), 0);

      // Basic block of four.
      cur_ln = 2;
      smp(10); smp(20); smp(30); smp(41);
      chk("t1_early", longint'(out_valid), 0);
      idle(1);
      chk("t1_valid", longint'(out_valid), 1);
      chk("t1_data", longint'(out_data), 25);
      idle(1);
      chk("t1_single", longint'(out_valid), 0);
      chk("t1_sat", longint'(sat_flag), 0);

      // Negative rounding.
      cur_ln = 1;
      smp(-3); smp(-4); idle(1);
      chk("t2_neg", longint'(out_data), -3);
      smp(-1); smp(0); idle(1);
      chk("t2_half", longint'(out_data), 0);

      // Saturation and the sticky flag.
      cur_ln = 0;
      smp(40000); idle(1);
      chk("t3_pos", longint'(out_data), 32767);
      chk("t3_flag", longint'(sat_flag), 1);
      step(0, 0, 0, 1, 0, cur_ln);
      chk("t3_clr", longint'(sat_flag), 0);
      smp(-40000); idle(1);
      chk("t3_neg", longint'(out_data), -32768);
      chk("t3_flag2", longint'(sat_flag), 1);
      step(0, 0, 0, 1, 0, cur_ln);
      smp(40000);
      step(0, 0, 0, 1, 0, cur_ln);
      chk("t3_set_wins", longint'(sat_flag), 1);
      step(0, 0, 0, 1, 0, cur_ln);

      // Gapped input.
      cur_ln  = 3;
      strobes = 0;
      for (int i = 0; i < 8; i++) begin
         smp(100);
         idle($urandom_range(0, 5));
      end
      idle(2);
      chk("t4_strobes", strobes, 1);
      chk("t4_data", longint'(out_data), 100);

      // Mid-block exponent change applies to the next block only.
      cur_ln = 2;
      smp(6); smp(6);
      cur_ln = 1;
      smp(6); smp(6); idle(1);
      chk("t5_blk4", longint'(out_data), 6);
      strobes = 0;
      smp(6); smp(6); idle(1);
      chk("t5_blk2", strobes, 1);

      // Flush by clear, then by reset.
      cur_ln = 2;
      smp(1000); smp(1000); smp(1000);
      step(0, 0, 1, 0, 0, cur_ln);
      smp(8); smp(8); smp(8); smp(8); idle(1);
      chk("t6_clear", longint'(out_data), 8);
      smp(1000); smp(1000); smp(1000);
      step(0, 0, 0, 0, 1, cur_ln);
      chk("t6_rst_data", longint'(out_data), 0);
      chk("t6_rst_valid", longint'(out_valid), 0);
      smp(8); smp(8); smp(8); smp(8); idle(1);
      chk("t6_after_rst", longint'(out_data), 8);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         longint d;
         if ($urandom_range(0, 3) == 0) d = longint'($signed($urandom));
         else d = longint'($urandom_range(0, 200000)) - 100000;
         if ($urandom_range(0, 15) == 0) cur_ln = $urandom_range(0, 31);
         else cur_ln = $urandom_range(0, 4);
         step($urandom_range(0, 3) != 0, d, $urandom_range(0, 29) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0, cur_ln);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lockin_decim_avg.md
Name: lockin_decim_avg

Overview:
- Downstream stage of the lock-in mixer multiplier: consumes the signed mixer product stream and applies an accumulate-and-dump decimating low-pass filter.
- Averages blocks of 2^N accepted samples, with N selectable at run time, then rounds, shifts and saturates the result to the output width.
- Emits one output word per block with a single-cycle valid strobe, for the demodulated I/Q path feeding the lock loop.

Parameters:
- IN_W, 32, signed input sample width (mixer product width).
- OUT_W, 16, signed output sample width.
- MAX_LOG2N, 16, maximum block-length exponent; larger requested values clamp to this.
- N_W, 5, width of log2_n; must satisfy 2^N_W > MAX_LOG2N.
- Derived localparam ACC_W = IN_W + MAX_LOG2N + 1. The extra bit is rounding headroom.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data is a sample to accept this cycle.
- in_data  in  IN_W  signed mixer product.
- log2_n  in  N_W  requested block length exponent; block length = 2^log2_n.
- clear  in  1  synchronous flush of the current block.
- sat_clr  in  1  clears sat_flag.
- out_valid  out  1  one-cycle strobe; out_data is new.
- out_data  out  OUT_W  signed rounded block mean.
- sat_flag  out  1  sticky; set when any output saturated.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - acc=0, cnt=0, n_lat=0, dump_valid=0.
  - out_valid=0, out_data=0, sat_flag=0.
- Accept rule: a sample is accepted at any edge where in_valid=1, clear=0 and rst=0. There is no back-pressure; every in_valid cycle is consumed.
- Block length latch:
  - n_lat <= min(log2_n, MAX_LOG2N) at the edge accepting the first sample of a block (cnt==0).
  - log2_n changes mid-block are ignored until the next block.
- Accumulation:
  - Each accepted sample does acc <= acc + sext(in_data), cnt <= cnt+1.
  - Final sample of a block is cnt == 2^n_lat − 1, including n_lat=0, where every sample is final.
  - At the edge accepting the final sample: dump <= acc + sext(in_data); dump_valid <= 1; acc <= 0; cnt <= 0.
  - A new block starts seamlessly on the next accepted sample.
- Stage 2 (edge after dump_valid=1):
  - r = dump + (n_lat_d>0 ? 2^(n_lat_d−1) : 0), then arithmetic shift right by n_lat_d. n_lat_d is the exponent captured with dump.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - out_data <= result; out_valid <= 1. Otherwise out_valid <= 0; out_data holds its last value.
- Latency: if the final sample is accepted at edge E, out_valid is high for exactly the cycle following edge E+1.
- Saturation flag:
  - sat_flag <= 1 when a stage-2 result saturated.
  - sat_clr=1 clears it.
  - Simultaneous set and sat_clr: set wins.
- clear:
  - Zeroes acc and cnt, and drops dump_valid. A pending dump is discarded, so no out_valid results from it.
  - A sample presented with clear=1 is discarded.
  - Does not affect out_data or sat_flag.
- Reset mid-block behaves as clear plus the reset values above.
- No overflow inside acc is possible: ACC_W covers 2^MAX_LOG2N full-scale samples plus rounding.

Decomposition:
- Package lockin_pkg:
  - Shared width constants: LOCKIN_PROD_W=32, LOCKIN_OUT_W=16, LOCKIN_MAX_LOG2N=16.
  - Function sat_signed(value, width).
- Sub-module round_shift_sat: combinational round-half-up, arithmetic shift and saturate.
  - Inputs: ACC_W value, shift amount.
  - Outputs: OUT_W result, sat bit.
  - Instantiated once in stage 2.

Test Plan:
- log2_n=2; accept 10,20,30,41 back-to-back. Expect out_data=25 ((101+2)>>2), out_valid for exactly 1 cycle, 2 edges after the last sample, sat_flag=0.
- log2_n=1; samples −3,−4. Expect out_data=−3 ((−7+1)>>>1). Then samples −1,0 give −0.5+0.5, so out_data=0.
- log2_n=0; sample 40000. Expect out_data=32767, sat_flag=1. Pulse sat_clr, expect sat_flag=0. Sample −40000: expect −32768, sat_flag=1. sat_clr held on the same cycle as a saturating result: expect sat_flag=1.
- log2_n=3; 8 samples of 100 with random 0–5 idle cycles between them. Expect exactly one out_valid with out_data=100, and no strobe during the gaps.
- log2_n=2; after 2 samples change log2_n to 1. Block completes after 4 samples of 6 (out=6). The next 2 samples of 6 give out=6 with n=1.
- log2_n=2; 3 samples of 1000, then clear. Next 4 samples of 8 give out_data=8. Repeat with rst in place of clear: expect all outputs at reset values, then out=8.
